// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   ctr_t       : 2-bit saturating predictor state (SNT/WNT/WT/ST)
//   CTR_RESET   : counter value after reset
//   CTR_ALLOC   : counter value given to a freshly allocated entry
//   btb_entry_t : one BTB line {valid, tag, target, ctr}
package mips_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  // The tag is held as PC >> (IDX_W+2) in a full 32-bit field so the entry
  // layout does not depend on the table size. The upper bits are simply zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Combinational next-state function of a 2-bit saturating predictor.
//   ctr      : current counter state
//   taken    : resolved branch outcome
//   ctr_next : counter moved one step toward taken/not-taken, clamped at ST/SNT
module btb_sat_counter
  import mips_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT: ctr_next = taken ? WNT : SNT;
      WNT: ctr_next = taken ? WT  : SNT;
      WT:  ctr_next = taken ? ST  : WNT;
      ST:  ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit predictors.
// Looks up the fetch PC combinationally and drives the IF next-PC mux; takes
// the branch resolution from ID, trains the table and recovers on mispredict.
//   CLK, RESET      : clock, asynchronous active-low reset
//   IF_PC           : current fetch PC
//   Branch/BTB_Addr : redirect fetch to BTB_Addr
//   IF_Flush        : squash the instruction entering IF/ID
//   ID_*            : resolution of a conditional branch in ID
//   Mispredict_Cnt  : saturating mispredict count
//
// Resolution contract: ID_Branch is a single-cycle qualifier. It is high only
// in the one cycle a non-stalled, non-flushed branch sits in ID; every other
// ID_* input is meaningful only while it is high. There is no back-pressure.
module branch_target_buffer
  import mips_pkg::*;
#(
  parameter int ENTRIES = 16,  // must equal 2**IDX_W
  parameter int IDX_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  output logic        Branch,
  output logic [31:0] BTB_Addr,
  output logic        IF_Flush,
  input  logic        ID_Branch,
  input  logic [31:0] ID_PC_4,
  input  logic        ID_Taken,
  input  logic [31:0] ID_Target,
  input  logic        ID_Pred_Taken,
  input  logic [31:0] ID_Pred_Addr,
  output logic [31:0] Mispredict_Cnt
);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      if_tag;
  logic [31:0]      bpc;
  logic [31:0]      bpc_tag;
  logic             hit;
  logic             pred;
  logic             upd_hit;
  logic             mp;
  logic [31:0]      rec;
  ctr_t             upd_ctr_next;
  logic [31:0]      cnt_q;

  // Lookup side
  assign idx    = IF_PC[IDX_W+1:2];
  assign if_tag = IF_PC >> (IDX_W + 2);
  assign hit    = btb_q[idx].valid && (btb_q[idx].tag == if_tag);
  assign pred   = hit && btb_q[idx].ctr[1];

  // Resolution side: the branch's own PC is recovered from PC+4.
  assign bpc     = ID_PC_4 - 32'd4;
  assign upd_idx = bpc[IDX_W+1:2];
  assign bpc_tag = bpc >> (IDX_W + 2);
  assign upd_hit = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == bpc_tag);

  // A correctly predicted taken branch with the wrong target is still a
  // mispredict: fetch went down the wrong path.
  assign mp  = ID_Branch &&
               ((ID_Pred_Taken != ID_Taken) ||
                (ID_Pred_Taken && ID_Taken && (ID_Pred_Addr != ID_Target)));
  assign rec = ID_Taken ? ID_Target : ID_PC_4;

  btb_sat_counter u_sat_counter (
    .ctr      (btb_q[upd_idx].ctr),
    .taken    (ID_Taken),
    .ctr_next (upd_ctr_next)
  );

  // Outputs are forced low while reset is held so the fetch mux sees a clean
  // sequential PC immediately, even if ID inputs are still active.
  always_comb begin
    Branch   = 1'b0;
    IF_Flush = 1'b0;
    BTB_Addr = btb_q[idx].target;
    if (!RESET) begin
      BTB_Addr = '0;
    end else if (mp) begin
      Branch   = 1'b1;
      IF_Flush = 1'b1;
      BTB_Addr = rec;
    end else if (pred) begin
      Branch   = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (ID_Branch) begin
      if (upd_hit) begin
        btb_q[upd_idx].ctr <= upd_ctr_next;
        if (ID_Taken) begin
          btb_q[upd_idx].target <= ID_Target;
        end
      end else if (ID_Taken) begin
        // Allocation replaces whatever aliasing branch held this slot.
        btb_q[upd_idx] <= '{valid: 1'b1, tag: bpc_tag, target: ID_Target,
                            ctr: CTR_ALLOC};
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q <= '0;
    end else if (mp && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign Mispredict_Cnt = cnt_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        CLK;
  logic        RESET;
  logic [31:0] IF_PC;
  logic        Branch;
  logic [31:0] BTB_Addr;
  logic        IF_Flush;
  logic        ID_Branch;
  logic [31:0] ID_PC_4;
  logic        ID_Taken;
  logic [31:0] ID_Target;
  logic        ID_Pred_Taken;
  logic [31:0] ID_Pred_Addr;
  logic [31:0] Mispredict_Cnt;

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IF_PC          (IF_PC),
    .Branch         (Branch),
    .BTB_Addr       (BTB_Addr),
    .IF_Flush       (IF_Flush),
    .ID_Branch      (ID_Branch),
    .ID_PC_4        (ID_PC_4),
    .ID_Taken       (ID_Taken),
    .ID_Target      (ID_Target),
    .ID_Pred_Taken  (ID_Pred_Taken),
    .ID_Pred_Addr   (ID_Pred_Addr),
    .Mispredict_Cnt (Mispredict_Cnt)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_cnt;

  function automatic int pc_index(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned pc_tag(input logic [31:0] pc);
    return int'(pc / (4 * ENTRIES));
  endfunction

  function automatic bit model_mp();
    if (!ID_Branch) return 1'b0;
    if (ID_Pred_Taken != ID_Taken) return 1'b1;
    return ID_Taken && (ID_Pred_Addr != ID_Target);
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i]  = 1'b0;
        m_tag[i]    = 0;
        m_target[i] = 32'h0;
        m_ctr[i]    = 1;
      end
      m_cnt = 32'h0;
    end else begin
      if (model_mp() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (ID_Branch) begin
        int          u;
        int unsigned t;
        u = pc_index(ID_PC_4 - 32'd4);
        t = pc_tag(ID_PC_4 - 32'd4);
        if (m_valid[u] && m_tag[u] == t) begin
          if (ID_Taken) begin
            m_ctr[u]    = (m_ctr[u] == 3) ? 3 : m_ctr[u] + 1;
            m_target[u] = ID_Target;
          end else begin
            m_ctr[u] = (m_ctr[u] == 0) ? 0 : m_ctr[u] - 1;
          end
        end else if (ID_Taken) begin
          m_valid[u]  = 1'b1;
          m_tag[u]    = t;
          m_target[u] = ID_Target;
          m_ctr[u]    = 2;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [33:0] exp_q[$];  // {Branch, IF_Flush, BTB_Addr}

  always @(negedge CLK) begin
    logic [33:0] e;
    int          i;
    bit          addr_care;
    i = pc_index(IF_PC);
    addr_care = 1'b1;
    if (!RESET) begin
      e = {1'b0, 1'b0, 32'h0};
    end else if (model_mp()) begin
      e = {1'b1, 1'b1, (ID_Taken ? ID_Target : ID_PC_4)};
    end else if (m_valid[i] && m_tag[i] == pc_tag(IF_PC) && m_ctr[i] >= 2) begin
      e = {1'b1, 1'b0, m_target[i]};
    end else begin
      e = {1'b0, 1'b0, 32'h0};
      addr_care = 1'b0;
    end
    exp_q.push_back(e);
    e = exp_q.pop_front();
    check_val("cyc_branch", {31'h0, Branch}, {31'h0, e[33]});
    check_val("cyc_flush", {31'h0, IF_Flush}, {31'h0, e[32]});
    if (addr_care) check_val("cyc_addr", BTB_Addr, e[31:0]);
    check_val("cyc_cnt", Mispredict_Cnt, m_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] pc, input logic br, input logic [31:0] pc4,
                       input logic tk, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] paddr);
    @(posedge CLK);
    #1;
    IF_PC         = pc;
    ID_Branch     = br;
    ID_PC_4       = pc4;
    ID_Taken      = tk;
    ID_Target     = tgt;
    ID_Pred_Taken = ptk;
    ID_Pred_Addr  = paddr;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  logic [31:0] fill_pc  [5];
  logic [31:0] fill_tgt [5];

  initial begin
    fill_pc  = '{32'h0000_0100, 32'h0000_0208, 32'h0000_030C, 32'h0000_1234, 32'h0000_7FF0};
    fill_tgt = '{32'h0000_0A00, 32'h0000_0B04, 32'h0000_0C08, 32'h0000_0D0C, 32'h0000_0E10};
    RESET = 1'b0;
    IF_PC = 32'h44;
    ID_Branch = 1'b0; ID_PC_4 = 32'h0; ID_Taken = 1'b0;
    ID_Target = 32'h0; ID_Pred_Taken = 1'b0; ID_Pred_Addr = 32'h0;

    @(negedge CLK);
    check_val("rst_branch", {31'h0, Branch}, 32'd0);
    check_val("rst_flush", {31'h0, IF_Flush}, 32'd0);
    check_val("rst_cnt", Mispredict_Cnt, 32'd0);
    @(posedge CLK); #2 RESET = 1'b1;

    // First resolution: unpredicted taken branch at 0x44
    drive(32'h44, 1, 32'h48, 1, 32'h100, 0, 32'h0);
    @(negedge CLK);
    check_val("a_branch", {31'h0, Branch}, 32'd1);
    check_val("a_addr", BTB_Addr, 32'h100);
    check_val("a_flush", {31'h0, IF_Flush}, 32'd1);
    idle(32'h44);
    @(negedge CLK);
    check_val("b_branch", {31'h0, Branch}, 32'd1);
    check_val("b_addr", BTB_Addr, 32'h100);
    check_val("b_flush", {31'h0, IF_Flush}, 32'd0);
    check_val("b_cnt", Mispredict_Cnt, 32'd1);
    // Correctly predicted: counter to ST, no flush
    drive(32'h44, 1, 32'h48, 1, 32'h100, 1, 32'h100);
    @(negedge CLK);
    check_val("c_flush", {31'h0, IF_Flush}, 32'd0);
    check_val("c_cnt", Mispredict_Cnt, 32'd1);
    // Two not-taken mispredicts
    drive(32'h44, 1, 32'h48, 0, 32'h100, 1, 32'h100);
    @(negedge CLK);
    check_val("d_addr", BTB_Addr, 32'h48);
    check_val("d_flush", {31'h0, IF_Flush}, 32'd1);
    drive(32'h44, 1, 32'h48, 0, 32'h100, 1, 32'h100);
    @(negedge CLK);
    check_val("e_addr", BTB_Addr, 32'h48);
    check_val("e_cnt", Mispredict_Cnt, 32'd2);
    idle(32'h44);
    @(negedge CLK);
    check_val("f_branch", {31'h0, Branch}, 32'd0);
    check_val("f_cnt", Mispredict_Cnt, 32'd3);
    // Alias at index 1 with tag 2
    idle(32'h84);
    @(negedge CLK);
    check_val("g_alias_branch", {31'h0, Branch}, 32'd0);
    drive(32'h10, 1, 32'h88, 1, 32'h200, 1, 32'h200);
    @(negedge CLK);
    check_val("h_flush", {31'h0, IF_Flush}, 32'd0);
    idle(32'h44);
    @(negedge CLK);
    check_val("i_evicted", {31'h0, Branch}, 32'd0);
    idle(32'h84);
    @(negedge CLK);
    check_val("j_branch", {31'h0, Branch}, 32'd1);
    check_val("j_addr", BTB_Addr, 32'h200);
    // Train down to SNT and beyond: must clamp at SNT
    for (int k = 0; k < 3; k++) drive(32'h84, 1, 32'h88, 0, 32'h0, 0, 32'h0);
    drive(32'h84, 1, 32'h88, 1, 32'h200, 0, 32'h0);
    @(negedge CLK);
    check_val("n_addr", BTB_Addr, 32'h200);
    idle(32'h84);
    @(negedge CLK);
    check_val("o_clamp_branch", {31'h0, Branch}, 32'd0);
    check_val("o_cnt", Mispredict_Cnt, 32'd4);
    // Taken with matching predicted target, then with wrong predicted target
    drive(32'h84, 1, 32'h88, 1, 32'h300, 1, 32'h300);
    drive(32'h84, 1, 32'h88, 1, 32'h400, 1, 32'h300);
    @(negedge CLK);
    check_val("q_tgt_mp_flush", {31'h0, IF_Flush}, 32'd1);
    check_val("q_tgt_mp_addr", BTB_Addr, 32'h400);
    idle(32'h84);
    @(negedge CLK);
    check_val("r_addr", BTB_Addr, 32'h400);
    check_val("r_cnt", Mispredict_Cnt, 32'd5);

    // Fill more entries, then sweep them
    for (int k = 0; k < 5; k++) drive(32'h0, 1, fill_pc[k] + 32'd4, 1, fill_tgt[k], 0, 32'h0);
    for (int k = 0; k < 5; k++) idle(fill_pc[k]);

    // Asynchronous reset between edges with a mispredict in flight
    drive(32'h84, 1, 32'h104, 0, 32'h0, 1, 32'h500);
    #2 RESET = 1'b0;
    #1;
    check_val("ar_branch", {31'h0, Branch}, 32'd0);
    check_val("ar_flush", {31'h0, IF_Flush}, 32'd0);
    check_val("ar_cnt", Mispredict_Cnt, 32'd0);
    check_val("ar_addr", BTB_Addr, 32'd0);
    ID_Branch = 1'b0;
    #3 RESET = 1'b1;
    idle(32'h84);
    @(negedge CLK);
    check_val("post_rst_miss", {31'h0, Branch}, 32'd0);
    for (int k = 0; k < 5; k++) idle(fill_pc[k]);
    idle(32'h44);
    repeat (2) @(posedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped BTB with 2-bit saturating predictors that drives the fetch-side `Branch` / `BTB_Addr` inputs of the IF next-PC mux.
- Looks up the current fetch PC combinationally and predicts taken/target.
- Accepts the branch resolution from the ID stage and updates its table.
- On a mispredict, raises `IF_Flush` and steers fetch to the recovery address through the existing `Branch` path.

Parameters:
- ENTRIES, 16, number of table entries; power of two, at least 2.
- IDX_W, 4, log2(ENTRIES); index bits are PC[IDX_W+1:2].

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IF_PC  in  32  current fetch PC (output of the PC register).
- Branch  out  1  redirect fetch to BTB_Addr (mux select bit 1).
- BTB_Addr  out  32  predicted target, or recovery address during a mispredict.
- IF_Flush  out  1  squash the instruction entering IF/ID this cycle.
- ID_Branch  in  1  one-cycle pulse: a conditional branch resolved in ID this cycle.
- ID_PC_4  in  32  PC+4 of the resolving branch (from IF/ID).
- ID_Taken  in  1  actual branch outcome.
- ID_Target  in  32  actual branch target.
- ID_Pred_Taken  in  1  prediction made in IF for this branch, piped through IF/ID.
- ID_Pred_Addr  in  32  target predicted in IF, piped through IF/ID.
- Mispredict_Cnt  out  32  count of mispredicts; saturates at 0xFFFFFFFF.

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], ctr[1:0].
- Reset (RESET low, immediate, no clock needed):
  - all valid bits = 0, all ctr = 01 (WNT);
  - Mispredict_Cnt = 0; Branch = 0; IF_Flush = 0; BTB_Addr = 0.
- Lookup (combinational, zero latency):
  - idx = IF_PC[IDX_W+1:2].
  - hit = valid[idx] && tag[idx] == IF_PC[31:IDX_W+2].
  - pred = hit && ctr[idx][1].
- Resolution: bpc = ID_PC_4 - 4. A mispredict (mp) is asserted when ID_Branch = 1 and any of:
  - ID_Pred_Taken != ID_Taken;
  - ID_Pred_Taken = 1, ID_Taken = 1 and ID_Pred_Addr != ID_Target.
- Recovery address (rec):
  - ID_Target if ID_Taken = 1;
  - ID_PC_4 if ID_Taken = 0.
- Outputs, priority order:
  - mp = 1: Branch = 1, BTB_Addr = rec, IF_Flush = 1.
  - mp = 0 and pred = 1: Branch = 1, BTB_Addr = target[idx], IF_Flush = 0.
  - otherwise: Branch = 0, BTB_Addr = target[idx] (don't-care), IF_Flush = 0.
- Table update on the rising edge when ID_Branch = 1; entry u = bpc[IDX_W+1:2]:
  - hit in u, ID_Taken = 1: ctr increments, saturating at 11; target <= ID_Target.
  - hit in u, ID_Taken = 0: ctr decrements, saturating at 00; target unchanged.
  - miss in u, ID_Taken = 1: allocate; valid = 1, tag = bpc tag, target = ID_Target, ctr = 10 (WT). Any aliasing entry is overwritten.
  - miss in u, ID_Taken = 0: no change.
- Counter: Mispredict_Cnt increments on each edge where mp = 1; holds at 0xFFFFFFFF.
- Simultaneous lookup and update of the same index: the lookup sees pre-edge table contents; mp override takes precedence in that cycle.
- Stalls: ID_Branch is qualified upstream (valid only when IF/ID is not stalled and not flushed), so each branch updates exactly once.
- Reset asserted mid-operation clears everything asynchronously; the first lookup after deassertion always misses.

Decomposition:
- Shared package (mips_pkg):
  - counter encodings SNT = 00, WNT = 01, WT = 10, ST = 11;
  - CTR_RESET = WNT, CTR_ALLOC = WT;
  - btb_entry_t struct {valid, tag, target, ctr}.
- Sub-module: btb_sat_counter, the combinational 2-bit saturating next-state function, instantiated once on the update path.

Test Plan:
- Reset, IF_PC = 0x44 -> Branch = 0, IF_Flush = 0, Mispredict_Cnt = 0.
- ID_Branch = 1, ID_PC_4 = 0x48, ID_Taken = 1, ID_Target = 0x100, ID_Pred_Taken = 0 -> same cycle Branch = 1, BTB_Addr = 0x100, IF_Flush = 1; next cycle IF_PC = 0x44 gives Branch = 1, BTB_Addr = 0x100; Mispredict_Cnt = 1.
- Same branch resolved taken with ID_Pred_Taken = 1, ID_Pred_Addr = 0x100 -> IF_Flush = 0, ctr 10 -> 11, count unchanged.
- Two not-taken resolutions with Pred_Taken = 1 -> each flushes with BTB_Addr = 0x48; ctr 11 -> 10 -> 01; then IF_PC = 0x44 gives Branch = 0; Mispredict_Cnt = 3.
- Alias: IF_PC = 0x84 (index 1, tag 2) while entry 1 holds tag 1 -> Branch = 0; taken resolution at 0x84 overwrites entry 1, after which IF_PC = 0x44 misses.
- RESET pulsed low between clock edges after table fill -> Branch, IF_Flush and Mispredict_Cnt drop to 0 immediately; all subsequent lookups miss.
